// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: ID/EX pipeline register with flush, stall, load-use bubble insertion and a saturating bubble counter.
module id_ex_pipeline_reg (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        ID_VALID,
  input  logic [31:0] ID_PC,
  input  logic [31:0] ID_IMMIDIATE,
  input  logic [31:0] ID_DATA1,
  input  logic [31:0] ID_DATA2,
  input  logic [4:0]  ID_RS1,
  input  logic [4:0]  ID_RS2,
  input  logic [4:0]  ID_RD,
  input  logic [4:0]  ID_ALU_OP,
  input  logic [2:0]  ID_FUNCT3,
  input  logic [7:0]  ID_CTRL,
  output logic        EX_VALID,
  output logic [31:0] EX_PC,
  output logic [31:0] EX_IMMIDIATE,
  output logic [31:0] EX_DATA1,
  output logic [31:0] EX_DATA2,
  output logic [4:0]  EX_RS1,
  output logic [4:0]  EX_RS2,
  output logic [4:0]  EX_RD,
  output logic [4:0]  EX_ALU_OP,
  output logic [2:0]  EX_FUNCT3,
  output logic [7:0]  EX_CTRL,
  output logic        LOAD_USE_STALL,
  output logic [15:0] BUBBLE_COUNT
);
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d, imm_q, imm_d, data1_q, data1_d, data2_q, data2_d;
  logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d, alu_op_q, alu_op_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [15:0] bubble_count_q, bubble_count_d;
  logic        capture, bubble;
  // x0 never carries a hazard, so a load targeting it is ignored
  assign LOAD_USE_STALL = valid_q && ctrl_q[1] && (rd_q != 5'd0) && ID_VALID &&
                          ((ID_RS1 == rd_q) || (ID_RS2 == rd_q));
  always_comb begin
    capture        = !FLUSH && !STALL && !LOAD_USE_STALL;
    bubble         = FLUSH || (!STALL && LOAD_USE_STALL);
    pc_d           = capture ? ID_PC : pc_q;
    imm_d          = capture ? ID_IMMIDIATE : imm_q;
    data1_d        = capture ? ID_DATA1 : data1_q;
    data2_d        = capture ? ID_DATA2 : data2_q;
    rs1_d          = capture ? ID_RS1 : rs1_q;
    rs2_d          = capture ? ID_RS2 : rs2_q;
    rd_d           = capture ? ID_RD : rd_q;
    alu_op_d       = capture ? ID_ALU_OP : alu_op_q;
    funct3_d       = capture ? ID_FUNCT3 : funct3_q;
    valid_d        = capture ? ID_VALID : (bubble ? 1'b0 : valid_q);
    ctrl_d         = (capture && ID_VALID) ? ID_CTRL : ((capture || bubble) ? 8'd0 : ctrl_q);
    bubble_count_d = (bubble && bubble_count_q != 16'hFFFF) ? bubble_count_q + 16'd1 : bubble_count_q;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q        <= 1'b0;
      pc_q           <= '0;
      imm_q          <= '0;
      data1_q        <= '0;
      data2_q        <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      rd_q           <= '0;
      alu_op_q       <= '0;
      funct3_q       <= '0;
      ctrl_q         <= '0;
      bubble_count_q <= '0;
    end else begin
      valid_q        <= valid_d;
      pc_q           <= pc_d;
      imm_q          <= imm_d;
      data1_q        <= data1_d;
      data2_q        <= data2_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      rd_q           <= rd_d;
      alu_op_q       <= alu_op_d;
      funct3_q       <= funct3_d;
      ctrl_q         <= ctrl_d;
      bubble_count_q <= bubble_count_d;
    end
  end
  assign EX_VALID     = valid_q;
  assign EX_PC        = pc_q;
  assign EX_IMMIDIATE = imm_q;
  assign EX_DATA1     = data1_q;
  assign EX_DATA2     = data2_q;
  assign EX_RS1       = rs1_q;
  assign EX_RS2       = rs2_q;
  assign EX_RD        = rd_q;
  assign EX_ALU_OP    = alu_op_q;
  assign EX_FUNCT3    = funct3_q;
  assign EX_CTRL      = ctrl_q;
  assign BUBBLE_COUNT = bubble_count_q;
endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// tb_id_ex_pipeline_reg: directed vectors plus a cycle-by-cycle reference model of the ID/EX register.
module tb_id_ex_pipeline_reg;
  logic        CLK = 0, RESET, STALL, FLUSH, ID_VALID;
  logic [31:0] ID_PC, ID_IMMIDIATE, ID_DATA1, ID_DATA2;
  logic [4:0]  ID_RS1, ID_RS2, ID_RD, ID_ALU_OP;
  logic [2:0]  ID_FUNCT3;
  logic [7:0]  ID_CTRL;
  logic        EX_VALID, LOAD_USE_STALL;
  logic [31:0] EX_PC, EX_IMMIDIATE, EX_DATA1, EX_DATA2;
  logic [4:0]  EX_RS1, EX_RS2, EX_RD, EX_ALU_OP;
  logic [2:0]  EX_FUNCT3;
  logic [7:0]  EX_CTRL;
  logic [15:0] BUBBLE_COUNT;
  int total = 0, bad = 0;
  id_ex_pipeline_reg dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH), .ID_VALID(ID_VALID),
    .ID_PC(ID_PC), .ID_IMMIDIATE(ID_IMMIDIATE), .ID_DATA1(ID_DATA1), .ID_DATA2(ID_DATA2),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD), .ID_ALU_OP(ID_ALU_OP),
    .ID_FUNCT3(ID_FUNCT3), .ID_CTRL(ID_CTRL),
    .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_IMMIDIATE(EX_IMMIDIATE), .EX_DATA1(EX_DATA1),
    .EX_DATA2(EX_DATA2), .EX_RS1(EX_RS1), .EX_RS2(EX_RS2), .EX_RD(EX_RD),
    .EX_ALU_OP(EX_ALU_OP), .EX_FUNCT3(EX_FUNCT3), .EX_CTRL(EX_CTRL),
    .LOAD_USE_STALL(LOAD_USE_STALL), .BUBBLE_COUNT(BUBBLE_COUNT)
  );
  always #5 CLK = ~CLK;
  typedef struct packed {
    logic        v;
    logic [31:0] pc, imm, d1, d2;
    logic [4:0]  rs1, rs2, rd, op;
    logic [2:0]  f3;
    logic [7:0]  ctrl;
  } ex_t;
  ex_t m = '0;
  int  bubbles = 0;
  function automatic logic hazard();
    return m.v && m.ctrl[1] && m.rd != 0 && ID_VALID && (ID_RS1 == m.rd || ID_RS2 == m.rd);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: bubble = instruction killed in place; data kept, valid and ctrl cleared
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m = '0;
      bubbles = 0;
    end else if (FLUSH || (!STALL && hazard())) begin
      m.v = 0;
      m.ctrl = 0;
      bubbles++;
    end else if (!STALL) begin
      m = '{v: ID_VALID, pc: ID_PC, imm: ID_IMMIDIATE, d1: ID_DATA1, d2: ID_DATA2,
            rs1: ID_RS1, rs2: ID_RS2, rd: ID_RD, op: ID_ALU_OP, f3: ID_FUNCT3,
            ctrl: ID_VALID ? ID_CTRL : 8'd0};
    end
  end
  always @(negedge CLK) begin
    chk("m_valid", {31'd0, EX_VALID}, {31'd0, m.v});
    chk("m_pc", EX_PC, m.pc);
    chk("m_imm", EX_IMMIDIATE, m.imm);
    chk("m_data1", EX_DATA1, m.d1);
    chk("m_data2", EX_DATA2, m.d2);
    chk("m_regs", {17'd0, EX_RS1, EX_RS2, EX_RD}, {17'd0, m.rs1, m.rs2, m.rd});
    chk("m_op_f3", {24'd0, EX_ALU_OP, EX_FUNCT3}, {24'd0, m.op, m.f3});
    chk("m_ctrl", {24'd0, EX_CTRL}, {24'd0, m.ctrl});
    chk("m_bubbles", {16'd0, BUBBLE_COUNT}, bubbles > 65535 ? 32'hFFFF : bubbles);
    chk("m_lus", {31'd0, LOAD_USE_STALL}, {31'd0, hazard()});
    if (!EX_VALID) chk("inv_ctrl", {24'd0, EX_CTRL}, 32'd0);
  end
  task automatic id(input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd, input logic [7:0] ctrl);
    ID_VALID = v; ID_PC = pc; ID_RS1 = rs1; ID_RS2 = rs2; ID_RD = rd; ID_CTRL = ctrl;
    ID_IMMIDIATE = pc ^ 32'hA5A5_0000; ID_DATA1 = pc + 32'd1; ID_DATA2 = ~pc;
    ID_ALU_OP = pc[6:2]; ID_FUNCT3 = pc[4:2];
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    RESET = 1; STALL = 0; FLUSH = 0;
    id(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_valid", {31'd0, EX_VALID}, 0);
    chk("rst_bubbles", {16'd0, BUBBLE_COUNT}, 0);
    chk("rst_lus", {31'd0, LOAD_USE_STALL}, 0);
    RESET = 0;
    id(1, 32'h100, 1, 2, 3, 8'h09);
    ID_IMMIDIATE = 32'hFFFF_FFF4;
    tick();
    chk("cap_pc", EX_PC, 32'h100);
    chk("cap_imm", EX_IMMIDIATE, 32'hFFFF_FFF4);
    chk("cap_ctrl", {24'd0, EX_CTRL}, 32'h09);
    chk("cap_valid", {31'd0, EX_VALID}, 1);
    id(1, 32'h104, 1, 2, 5, 8'h03);
    tick();
    id(1, 32'h108, 5, 6, 7, 8'h01);
    #1 chk("lu_rs1", {31'd0, LOAD_USE_STALL}, 1);
    tick();
    chk("lu_bub_valid", {31'd0, EX_VALID}, 0);
    chk("lu_bub_ctrl", {24'd0, EX_CTRL}, 0);
    chk("lu_bub_pc", EX_PC, 32'h104);
    chk("lu_bub_cnt", {16'd0, BUBBLE_COUNT}, 1);
    chk("lu_clear", {31'd0, LOAD_USE_STALL}, 0);
    tick();
    chk("lu_cap_pc", EX_PC, 32'h108);
    chk("lu_cap_valid", {31'd0, EX_VALID}, 1);
    id(1, 32'h10C, 1, 2, 0, 8'h03);
    tick();
    id(1, 32'h110, 0, 0, 3, 8'h01);
    #1 chk("x0_lus", {31'd0, LOAD_USE_STALL}, 0);
    tick();
    chk("x0_pc", EX_PC, 32'h110);
    chk("x0_cnt", {16'd0, BUBBLE_COUNT}, 1);
    id(1, 32'h114, 1, 2, 9, 8'h03);
    tick();
    id(1, 32'h118, 4, 9, 10, 8'h01);
    STALL = 1;
    #1 chk("lu_rs2", {31'd0, LOAD_USE_STALL}, 1);
    tick();
    chk("stall_over_lu_valid", {31'd0, EX_VALID}, 1);
    chk("stall_over_lu_cnt", {16'd0, BUBBLE_COUNT}, 1);
    STALL = 0;
    tick();
    chk("lu2_cnt", {16'd0, BUBBLE_COUNT}, 2);
    tick();
    chk("lu2_cap_pc", EX_PC, 32'h118);
    id(0, 32'h11C, 1, 2, 3, 8'hFF);
    tick();
    chk("inv_cap_ctrl", {24'd0, EX_CTRL}, 0);
    chk("inv_cap_pc", EX_PC, 32'h11C);
    id(1, 32'h200, 1, 2, 3, 8'h61);
    tick();
    STALL = 1; FLUSH = 1;
    tick();
    chk("sf_valid", {31'd0, EX_VALID}, 0);
    chk("sf_ctrl", {24'd0, EX_CTRL}, 0);
    chk("sf_pc", EX_PC, 32'h200);
    chk("sf_cnt", {16'd0, BUBBLE_COUNT}, 3);
    STALL = 0; FLUSH = 0;
    id(1, 32'h300, 1, 2, 3, 8'h85);
    tick();
    STALL = 1;
    id(1, 32'h400, 4, 5, 6, 8'h11);
    tick(); tick(); tick();
    chk("hold_pc", EX_PC, 32'h300);
    chk("hold_ctrl", {24'd0, EX_CTRL}, 32'h85);
    chk("hold_cnt", {16'd0, BUBBLE_COUNT}, 3);
    #2 RESET = 1;
    #1 chk("arst_valid", {31'd0, EX_VALID}, 0);
    chk("arst_pc", EX_PC, 0);
    chk("arst_cnt", {16'd0, BUBBLE_COUNT}, 0);
    chk("arst_lus", {31'd0, LOAD_USE_STALL}, 0);
    #2 RESET = 0;
    STALL = 0;
    id(1, 32'h500, 1, 2, 3, 8'h01);
    tick();
    chk("post_rst_pc", EX_PC, 32'h500);
    chk("post_rst_valid", {31'd0, EX_VALID}, 1);
    FLUSH = 1;
    repeat (65535) @(posedge CLK);
    #1 chk("sat_reach", {16'd0, BUBBLE_COUNT}, 32'hFFFF);
    tick();
    chk("sat_hold", {16'd0, BUBBLE_COUNT}, 32'hFFFF);
    FLUSH = 0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
